// File: rtl/flash_mux_pkg.sv
// rtl/flash_mux_pkg.sv - shared state type, idle level and select-width helper for the flash MISO mux
package flash_mux_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } flash_state_e;

   // Level a floating MISO line settles to through the board pull-up.
   localparam logic FLASH_IDLE_LEVEL = 1'b1;

   function automatic int sel_width(input int num_flash);
      return (num_flash <= 2) ? 1 : $clog2(num_flash);
   endfunction

endpackage

// File: rtl/flash_sel_lock.sv
// rtl/flash_sel_lock.sv - per-transaction select lock: FSM, lock register, range check and sticky sel_err
module flash_sel_lock
   import flash_mux_pkg::*;
#(
   parameter int NUM_FLASH = 2,
   parameter int SEL_W     = sel_width(NUM_FLASH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             h_cs_n,
   input  logic [SEL_W-1:0] flash_select,
   input  logic             err_clr,
   output logic [SEL_W-1:0] lock_sel,
   output logic             lock_valid,
   output logic             busy,
   output logic             sel_err
);

   localparam logic [SEL_W:0] NUM_FLASH_V = (SEL_W + 1)'(NUM_FLASH);

   flash_state_e     state_q, state_d;
   logic [SEL_W-1:0] lock_q, lock_d;
   logic             valid_q, valid_d;
   logic             armed_q, armed_d;
   logic             err_q, err_d;
   logic             sel_in_range;
   logic             start;
   logic             mismatch;
   logic             err_set;

   assign sel_in_range = ({1'b0, flash_select} < NUM_FLASH_V);

   // A chip select still low when reset releases belongs to the aborted
   // transaction; a high sample must be seen before the next lock.
   assign start    = (state_q == ST_IDLE) && armed_q && !h_cs_n;
   assign mismatch = (state_q == ST_ACTIVE) && (flash_select != lock_q);
   assign err_set  = (start && !sel_in_range) || mismatch;

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      valid_d = valid_q;
      armed_d = armed_q | h_cs_n;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACTIVE;
               lock_d  = flash_select;
               valid_d = sel_in_range;
            end
         end
         ST_ACTIVE: begin
            if (h_cs_n) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lock_q  <= '0;
         valid_q <= 1'b0;
         armed_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         valid_q <= valid_d;
         armed_q <= armed_d;
         err_q   <= err_d;
      end
   end

   assign lock_sel   = lock_q;
   assign lock_valid = valid_q;
   assign busy       = (state_q == ST_ACTIVE);
   assign sel_err    = err_q;

endmodule

// File: rtl/flash_miso_mux_n.sv
// rtl/flash_miso_mux_n.sv - host MISO lane mux over NUM_FLASH flashes
// FLASH_MUX_PIPE_EN adds an output register on h_miso.
module flash_miso_mux_n
   import flash_mux_pkg::*;
#(
   parameter int NUM_FLASH = 2,
   parameter int DATA_W    = 1,
   parameter int SEL_W     = sel_width(NUM_FLASH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_FLASH*DATA_W-1:0] f_miso,
   input  logic                        h_cs_n,
   input  logic [SEL_W-1:0]            flash_select,
   input  logic                        err_clr,
   output logic [DATA_W-1:0]           h_miso,
   output logic [SEL_W-1:0]            active_sel,
   output logic                        busy,
   output logic                        sel_err
);

   localparam logic [DATA_W-1:0] IDLE_WORD = {DATA_W{FLASH_IDLE_LEVEL}};

   logic [SEL_W-1:0]  lock_sel;
   logic              lock_valid;
   logic [DATA_W-1:0] mux_data;

   flash_sel_lock #(
      .NUM_FLASH (NUM_FLASH),
      .SEL_W     (SEL_W)
   ) u_sel_lock (
      .clk          (clk),
      .rst_n        (rst_n),
      .h_cs_n       (h_cs_n),
      .flash_select (flash_select),
      .err_clr      (err_clr),
      .lock_sel     (lock_sel),
      .lock_valid   (lock_valid),
      .busy         (busy),
      .sel_err      (sel_err)
   );

   // An out-of-range lock never matches a lane, so it leaves the idle level.
   always_comb begin
      mux_data = IDLE_WORD;
      if (busy && lock_valid) begin
         for (int i = 0; i < NUM_FLASH; i++) begin
            if (lock_sel == SEL_W'(i)) begin
               mux_data = f_miso[i*DATA_W +: DATA_W];
            end
         end
      end
   end

`ifdef FLASH_MUX_PIPE_EN
   logic [DATA_W-1:0] h_miso_q, h_miso_d;

   assign h_miso_d = mux_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_miso_q <= IDLE_WORD;
      end else begin
         h_miso_q <= h_miso_d;
      end
   end

   assign h_miso = h_miso_q;
`else
   assign h_miso = mux_data;
`endif

   assign active_sel = lock_sel;

endmodule

// File: tb/tb_flash_miso_mux_n.sv
// tb/tb_flash_miso_mux_n.sv - directed scoreboard bench for flash_miso_mux_n (3x1 and 4x4 instances)
module tb_flash_miso_mux_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        h_cs_n;
   logic [1:0]  flash_select;
   logic        err_clr;
   logic [2:0]  f_a;
   logic [15:0] f_b;

   logic        a_h, a_busy, a_err;
   logic [1:0]  a_asel;
   logic [3:0]  b_h;
   logic        b_busy, b_err;
   logic [1:0]  b_asel;

   int          n_pass  = 0;
   int          n_fail  = 0;
   int          n_total = 0;
   int          step_no = 0;
   logic        tgt     = 1'b0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   flash_miso_mux_n #(.NUM_FLASH(3), .DATA_W(1)) u_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .f_miso       (f_a),
      .h_cs_n       (h_cs_n),
      .flash_select (flash_select),
      .err_clr      (err_clr),
      .h_miso       (a_h),
      .active_sel   (a_asel),
      .busy         (a_busy),
      .sel_err      (a_err)
   );

   flash_miso_mux_n #(.NUM_FLASH(4), .DATA_W(4)) u_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .f_miso       (f_b),
      .h_cs_n       (h_cs_n),
      .flash_select (flash_select),
      .err_clr      (err_clr),
      .h_miso       (b_h),
      .active_sel   (b_asel),
      .busy         (b_busy),
      .sel_err      (b_err)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_a_busy"}, 16'(a_busy), 16'h0);
      chk({tag, "_a_asel"}, 16'(a_asel), 16'h0);
      chk({tag, "_a_err"},  16'(a_err),  16'h0);
      chk({tag, "_a_h"},    16'(a_h),    16'h1);
      chk({tag, "_b_busy"}, 16'(b_busy), 16'h0);
      chk({tag, "_b_asel"}, 16'(b_asel), 16'h0);
      chk({tag, "_b_err"},  16'(b_err),  16'h0);
      chk({tag, "_b_h"},    16'(b_h),    16'hF);
   endtask

   // eh: h_miso for the state held before this edge with these f_miso values;
   // eb/ea/ee: busy/active_sel/sel_err after this edge.
   task automatic step(input logic cs, input logic [1:0] s, input logic clr,
                       input logic [2:0] fa, input logic [15:0] fb,
                       input logic [15:0] eh, input logic eb, input logic [1:0] ea,
                       input logic ee);
      logic [15:0] exp_h;
      h_cs_n       = cs;
      flash_select = s;
      err_clr      = clr;
      f_a          = fa;
      f_b          = fb;
      exp_q.push_back(eh);
      step_no++;
      #1;
`ifndef FLASH_MUX_PIPE_EN
      exp_h = exp_q.pop_front();
      chk($sformatf("s%0d_h_miso", step_no), tgt ? 16'(b_h) : 16'(a_h), exp_h);
`endif
      @(posedge clk);
      #1;
`ifdef FLASH_MUX_PIPE_EN
      exp_h = exp_q.pop_front();
      chk($sformatf("s%0d_h_miso", step_no), tgt ? 16'(b_h) : 16'(a_h), exp_h);
`endif
      chk($sformatf("s%0d_busy", step_no), tgt ? 16'(b_busy) : 16'(a_busy), 16'(eb));
      chk($sformatf("s%0d_active_sel", step_no), tgt ? 16'(b_asel) : 16'(a_asel), 16'(ea));
      chk($sformatf("s%0d_sel_err", step_no), tgt ? 16'(b_err) : 16'(a_err), 16'(ee));
      @(negedge clk);
   endtask

   initial begin
      rst_n        = 1'b0;
      h_cs_n       = 1'b1;
      flash_select = 2'd0;
      err_clr      = 1'b0;
      f_a          = 3'b000;
      f_b          = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk_reset("rst");
      rst_n = 1'b1;

      // instance A: 3 flashes x 1 lane
      tgt = 1'b0;
      step(1, 2'd0, 0, 3'b000, 16'h0, 16'h1, 0, 2'd0, 0);
      // lock flash 1, lane 1 toggles; lanes 0/2 held high
      step(0, 2'd1, 0, 3'b111, 16'h0, 16'h1, 1, 2'd1, 0);
      step(0, 2'd1, 0, 3'b111, 16'h0, 16'h1, 1, 2'd1, 0);
      step(0, 2'd1, 0, 3'b101, 16'h0, 16'h0, 1, 2'd1, 0);
      step(0, 2'd1, 0, 3'b111, 16'h0, 16'h1, 1, 2'd1, 0);
      step(1, 2'd1, 0, 3'b101, 16'h0, 16'h0, 0, 2'd1, 0);
      step(1, 2'd1, 0, 3'b111, 16'h0, 16'h1, 0, 2'd1, 0);
      // out-of-range select 3 on a 3-flash mux
      step(0, 2'd3, 0, 3'b000, 16'h0, 16'h1, 1, 2'd3, 1);
      step(0, 2'd3, 0, 3'b000, 16'h0, 16'h1, 1, 2'd3, 1);
      step(1, 2'd3, 0, 3'b000, 16'h0, 16'h1, 0, 2'd3, 1);
      step(1, 2'd0, 1, 3'b000, 16'h0, 16'h1, 0, 2'd3, 0);
      // back-to-back: flash 0, one high sample, then flash 1
      step(0, 2'd0, 0, 3'b010, 16'h0, 16'h1, 1, 2'd0, 0);
      step(0, 2'd0, 0, 3'b010, 16'h0, 16'h0, 1, 2'd0, 0);
      step(1, 2'd0, 0, 3'b010, 16'h0, 16'h0, 0, 2'd0, 0);
      step(0, 2'd1, 0, 3'b100, 16'h0, 16'h1, 1, 2'd1, 0);
      step(0, 2'd1, 0, 3'b101, 16'h0, 16'h0, 1, 2'd1, 0);
      step(1, 2'd1, 0, 3'b101, 16'h0, 16'h0, 0, 2'd1, 0);
      step(1, 2'd1, 0, 3'b000, 16'h0, 16'h1, 0, 2'd1, 0);
      // reset mid-transaction with chip select held low
      step(0, 2'd2, 0, 3'b000, 16'h0, 16'h1, 1, 2'd2, 0);
      step(0, 2'd2, 0, 3'b000, 16'h0, 16'h0, 1, 2'd2, 0);
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 2'd2, 0, 3'b000, 16'h0, 16'h1, 0, 2'd0, 0);
      step(0, 2'd2, 0, 3'b000, 16'h0, 16'h1, 0, 2'd0, 0);
      step(1, 2'd2, 0, 3'b000, 16'h0, 16'h1, 0, 2'd0, 0);
      step(0, 2'd2, 0, 3'b000, 16'h0, 16'h1, 1, 2'd2, 0);
      step(0, 2'd2, 0, 3'b000, 16'h0, 16'h0, 1, 2'd2, 0);
      step(1, 2'd2, 0, 3'b000, 16'h0, 16'h0, 0, 2'd2, 0);
      step(1, 2'd2, 0, 3'b000, 16'h0, 16'h1, 0, 2'd2, 0);

      // instance B: 4 flashes x 4 lanes, lock flash 2 then glitch the select
      tgt = 1'b1;
      step(1, 2'd2, 1, 3'b000, 16'h3A5C, 16'hF, 0, 2'd2, 0);
      step(0, 2'd2, 0, 3'b000, 16'h3A5C, 16'hF, 1, 2'd2, 0);
      step(0, 2'd2, 0, 3'b000, 16'h3A5C, 16'hA, 1, 2'd2, 0);
      step(0, 2'd3, 0, 3'b000, 16'h3A5C, 16'hA, 1, 2'd2, 1);
      step(0, 2'd3, 0, 3'b000, 16'h1601, 16'h6, 1, 2'd2, 1);
      step(0, 2'd2, 0, 3'b000, 16'h1601, 16'h6, 1, 2'd2, 1);
      step(0, 2'd2, 1, 3'b000, 16'h1601, 16'h6, 1, 2'd2, 0);
      // clear and a fresh violation on the same edge: set wins
      step(0, 2'd1, 1, 3'b000, 16'h1601, 16'h6, 1, 2'd2, 1);
      step(1, 2'd2, 0, 3'b000, 16'h1601, 16'h6, 0, 2'd2, 1);
      step(1, 2'd2, 0, 3'b000, 16'h1601, 16'hF, 0, 2'd2, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/flash_miso_mux_n.md
# flash_miso_mux_n

Parametrised host-side MISO multiplexer for the SPI flash RAID path. It routes one of `NUM_FLASH` flash MISO buses, each `DATA_W` lanes wide (single/dual/quad SPI), to the host. The selection is latched at the start of each chip-select transaction and held until it ends. It sits between the instruction decoder, which supplies `flash_select`, and the host SPI pins. Select changes mid-transaction are ignored and flagged, so a decoder glitch can never switch flashes partway through a read.

## Interface
Parameters:
- `NUM_FLASH`, default 2: number of flash devices, 2..8.
- `DATA_W`, default 1: MISO lanes per flash, one of 1, 2 or 4.
- `SEL_W`, default `$clog2(NUM_FLASH)` (minimum 1): select width.

Ports:
- `clk`  in  1: system clock; all host/flash SPI pins are sampled in this domain.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `f_miso`  in  `NUM_FLASH*DATA_W`: flash MISO buses; flash i occupies bits `[i*DATA_W +: DATA_W]`.
- `h_cs_n`  in  1: host chip select, active-low.
- `flash_select`  in  `SEL_W`: requested flash index, from the decoder.
- `err_clr`  in  1: one-cycle pulse that clears `sel_err`.
- `h_miso`  out  `DATA_W`: MISO to the host.
- `active_sel`  out  `SEL_W`: locked flash index.
- `busy`  out  1: high while a transaction is locked.
- `sel_err`  out  1: sticky select-violation flag.

## Operation
FSM states are IDLE and ACTIVE.

IDLE:
- `h_miso` is all-ones (pull-up level) and `busy` = 0.
- On a clock edge that samples `h_cs_n` = 0:
  - latch the `flash_select` value present at that edge into the lock register;
  - go to ACTIVE.
- Select values sampled in IDLE at any other edge are don't-care.

ACTIVE:
- `busy` = 1.
- `h_miso` = `f_miso` slice of the locked index. This path is combinational unless the pipeline option is compiled in.
- If `flash_select` differs from the locked value at any edge, set `sel_err`. The lock is never changed mid-transaction.
- On an edge that samples `h_cs_n` = 1, go to IDLE.

Out-of-range select (value ≥ `NUM_FLASH`) when latched:
- enter ACTIVE anyway;
- `h_miso` stays all-ones for the whole transaction;
- `sel_err` is set on the latching edge.

`sel_err`:
- Sticky; cleared by `err_clr`.
- If set and clear happen in the same cycle, set wins.

`active_sel`:
- Holds its last locked value in IDLE.
- Resets to 0.

## Timing
Reset values (asynchronous, immediate on `rst_n` low):
- state = IDLE, `h_miso` = all-ones, `busy` = 0, `active_sel` = 0, `sel_err` = 0.

Cycle timing:
- `h_cs_n` falling → `busy` high at the first clock edge that samples it low (1-cycle detection latency).
- Data path, ACTIVE, no pipeline: zero-cycle latency from `f_miso` to `h_miso`.
- `h_cs_n` rising → `busy` low and `h_miso` all-ones after the first edge that samples it high.
- Back-to-back transactions: a `h_cs_n` high pulse of exactly one sampled cycle must produce one IDLE cycle. The next low sample re-latches `flash_select`.

Reset mid-transaction:
- Immediate return to IDLE and reset values.
- The transaction is not resumed after `rst_n` deasserts, even if `h_cs_n` is still low. A new low sample after reset starts a fresh lock.

## Configuration
- `FLASH_MUX_PIPE_EN` defined:
  - `h_miso` is registered;
  - all `h_miso` timings above gain +1 cycle;
  - the registered value resets to all-ones;
  - `busy`, `active_sel` and `sel_err` timing is unchanged.
- Undefined: combinational data path as described in Operation.

## Structure
Package `flash_mux_pkg` contains:
- state enum (IDLE, ACTIVE);
- `FLASH_IDLE_LEVEL` constant (1'b1, replicated per lane);
- select-width helper function.

Sub-module `flash_sel_lock` contains:
- the FSM, lock register, range check and `sel_err` logic;
- outputs: locked index, valid bit, `busy`.

The top level instantiates `flash_sel_lock` and implements the lane mux plus the optional output register.

## Test plan
- `NUM_FLASH`=2, `DATA_W`=1: `flash_select`=1, `h_cs_n` low, `f_miso[1]` toggling 1010 → `h_miso` follows it from the cycle after the lock; `active_sel`=1; `busy`=1.
- `NUM_FLASH`=4, `DATA_W`=4: lock flash 2, then change `flash_select` to 3 mid-transaction → `h_miso` still equals `f_miso[11:8]`; `sel_err`=1 the cycle after the change and stays 1 until `err_clr`.
- `NUM_FLASH`=3: `flash_select`=3 at the latching edge → `h_miso`=1 for the whole transaction; `sel_err` set; `busy`=1.
- Back-to-back: transaction on flash 0, `h_cs_n` high for 1 cycle, then low with select 1 → exactly one IDLE cycle with `h_miso` all-ones, then flash 1 data.
- `rst_n` pulsed low mid-ACTIVE with `h_cs_n` held low → all outputs return to reset values immediately; no re-lock until `h_cs_n` goes high then low again.
- `err_clr` and a new violation in the same cycle → `sel_err` stays 1. With `FLASH_MUX_PIPE_EN` defined, rerun the first scenario and confirm +1 cycle `h_miso` latency.
